// File: rtl/numlock_pkg.sv
// numlock_pkg
//   Shared definitions for the number-lock entry controller:
//   - state_t : controller FSM state, 2-bit encoding (IDLE=0, OPEN=1,
//               WAIT_ACK=2, LOCK=3)
//   - DEF_*   : default values for the controller parameters
package numlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_LOCK     = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_TICKS = 4;
    localparam int DEF_OPEN_TICKS     = 6;
    localparam int DEF_MAX_BAD        = 3;
    localparam int DEF_LOCKOUT_TICKS  = 10;
    localparam int DEF_TIMER_W        = 16;

endpackage

// File: rtl/numlock_debouncer.sv
// numlock_debouncer
//   Brings one raw asynchronous button into the clock domain, debounces it
//   against the slow tick, and flags each 0->1 change of the debounced level.
//   Ports:
//     i_Clk   - clock, rising edge
//     i_reset - synchronous active-high reset
//     i_tick  - slow time-base enable (one Clk wide)
//     i_btn   - raw asynchronous button
//     o_rise  - high for one Clk when the debounced level goes 0->1
module numlock_debouncer
    import numlock_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic i_Clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any return to the current level restarts the stability count,
            // so a bounce must be absent for a full run of ticks.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/numlock_entry_ctrl.sv
// numlock_entry_ctrl
//   Sequencer between the board buttons / tick source and the number-lock SM.
//   Debounces U/Z into symbol pulses (colliding presses dropped), times the
//   OPENING dwell with a level timerout handshake, counts bad attempts and
//   enforces a timed lockout during which all entry is ignored.
//   Ports:
//     i_Clk, i_reset          - clock / synchronous active-high reset
//     i_tick                  - slow time-base enable
//     i_btn_u, i_btn_z        - raw buttons
//     i_q_opening, i_q_bad    - one-hot state bits fed back from the SM
//     o_u_pulse, o_z_pulse    - one-Clk symbol pulses
//     o_collision             - one-Clk pulse when U and Z press together
//     o_timerout              - high in WAIT_ACK until q_opening drops
//     o_lockout               - high while locked out
//     o_bad_count             - bad attempts so far
//     o_timer_value           - remaining ticks of OPEN / LOCK phase, else 0
module numlock_entry_ctrl
    import numlock_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int OPEN_TICKS     = DEF_OPEN_TICKS,
    parameter int MAX_BAD        = DEF_MAX_BAD,
    parameter int LOCKOUT_TICKS  = DEF_LOCKOUT_TICKS,
    parameter int TIMER_W        = DEF_TIMER_W
) (
    input  logic                           i_Clk,
    input  logic                           i_reset,
    input  logic                           i_tick,
    input  logic                           i_btn_u,
    input  logic                           i_btn_z,
    input  logic                           i_q_opening,
    input  logic                           i_q_bad,
    output logic                           o_u_pulse,
    output logic                           o_z_pulse,
    output logic                           o_collision,
    output logic                           o_timerout,
    output logic                           o_lockout,
    output logic [$clog2(MAX_BAD+1)-1:0]   o_bad_count,
    output logic [TIMER_W-1:0]             o_timer_value
);

    localparam int BC_W = $clog2(MAX_BAD + 1);

    state_t             r_state;
    state_t             w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [BC_W-1:0]    r_bad;
    logic [BC_W-1:0]    w_bad_inc;
    logic               r_q_open_d;
    logic               r_q_bad_d;
    logic               w_open_rise;
    logic               w_bad_rise;
    logic               w_timer_last;
    logic               w_u_rise;
    logic               w_z_rise;
    logic               r_u_pulse;
    logic               r_z_pulse;
    logic               r_collision;

    // ---------------- buttons ----------------
    numlock_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_u (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .i_btn   (i_btn_u),
        .o_rise  (w_u_rise)
    );

    numlock_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_z (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .i_btn   (i_btn_z),
        .o_rise  (w_z_rise)
    );

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_u_pulse   <= 1'b0;
            r_z_pulse   <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_u_pulse   <= w_u_rise & ~w_z_rise & ~o_lockout;
            r_z_pulse   <= w_z_rise & ~w_u_rise & ~o_lockout;
            r_collision <= w_u_rise &  w_z_rise & ~o_lockout;
        end
    end

    assign o_u_pulse   = r_u_pulse;
    assign o_z_pulse   = r_z_pulse;
    assign o_collision = r_collision;

    // ---------------- SM feedback edges ----------------
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_q_open_d <= 1'b0;
            r_q_bad_d  <= 1'b0;
        end else begin
            r_q_open_d <= i_q_opening;
            r_q_bad_d  <= i_q_bad;
        end
    end

    assign w_open_rise  = i_q_opening & ~r_q_open_d;
    assign w_bad_rise   = i_q_bad & ~r_q_bad_d;
    assign w_timer_last = i_tick && (r_timer == TIMER_W'(1));
    assign w_bad_inc    = (r_bad == BC_W'(MAX_BAD)) ? r_bad : r_bad + BC_W'(1);

    // ---------------- FSM ----------------
    always_ff @(posedge i_Clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // OPENING outranks a simultaneous bad attempt
                if (w_open_rise)
                    w_next = ST_OPEN;
                else if (w_bad_rise && (w_bad_inc == BC_W'(MAX_BAD)))
                    w_next = ST_LOCK;
            end
            ST_OPEN: begin
                // early exit outranks a final tick on the same cycle
                if (!i_q_opening)      w_next = ST_IDLE;
                else if (w_timer_last) w_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!i_q_opening) w_next = ST_IDLE;
            end
            ST_LOCK: begin
                if (w_timer_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_timerout = (r_state == ST_WAIT_ACK);
        o_lockout  = (r_state == ST_LOCK);
    end

    // ---------------- shared timer and bad counter ----------------
    // A load on state entry takes priority over a tick on the same cycle,
    // so ticks are only counted from the cycle after entry.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_timer <= '0;
            r_bad   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_open_rise) begin
                        r_timer <= TIMER_W'(OPEN_TICKS);
                        r_bad   <= '0;
                    end else if (w_bad_rise) begin
                        r_bad <= w_bad_inc;
                        if (w_next == ST_LOCK)
                            r_timer <= TIMER_W'(LOCKOUT_TICKS);
                    end
                end
                ST_OPEN: begin
                    if (!i_q_opening)
                        r_timer <= '0;
                    else if (i_tick && (r_timer != '0))
                        r_timer <= r_timer - TIMER_W'(1);
                end
                ST_LOCK: begin
                    if (i_tick && (r_timer != '0))
                        r_timer <= r_timer - TIMER_W'(1);
                    if (w_timer_last)
                        r_bad <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_bad_count   = r_bad;
    assign o_timer_value = r_timer;

endmodule

// File: doc/numlock_entry_ctrl.md
# numlock_entry_ctrl

Sequencing controller in front of the number-lock state machine. It debounces the raw U/Z buttons into single-cycle symbol pulses and drops colliding presses. It times the OPENING dwell and drives `timerout` as a level handshake. It counts bad attempts and imposes a timed lockout during which all entry is ignored. It sits between the board buttons and tick source on one side and the `ee201_numlock_sm` inputs on the other.

## Interface
- `DEBOUNCE_TICKS`, default 4: consecutive ticks a raw button must be stable before its debounced level changes.
- `OPEN_TICKS`, default 6: ticks OPENING is held before `timerout` asserts.
- `MAX_BAD`, default 3: bad attempts that trigger lockout.
- `LOCKOUT_TICKS`, default 10: lockout duration in ticks.
- `TIMER_W`, default 16: width of the shared tick timer.
- `Clk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-`Clk` enable pulse, the slow time base.
- `btn_u`, `btn_z` in 1 each: raw, asynchronous buttons.
- `q_opening`, `q_bad` in 1 each: one-hot state bits fed back from the SM.
- `u_pulse`, `z_pulse` out 1 each: one-cycle symbol pulses to the SM `u` and `z` inputs.
- `collision` out 1: one-cycle pulse when both debounced presses rise in the same cycle.
- `timerout` out 1: level handshake to the SM.
- `lockout` out 1: high while in LOCKOUT.
- `bad_count` out $clog2(MAX_BAD+1): current count of bad attempts.
- `timer_value` out TIMER_W: remaining ticks in the current OPEN or LOCK phase, 0 otherwise.

## Operation
- Synchronizer:
  - Each raw button passes through a 2-flop synchronizer.
  - The debounce counter per button counts only on `tick` while the synchronized value differs from the debounced level.
  - The counter clears when the values match.
  - At count `DEBOUNCE_TICKS` the debounced level takes the synchronized value and the counter clears.
- Press detect:
  - A 0→1 change of a debounced level is a press.
  - A U press alone gives `u_pulse`; a Z press alone gives `z_pulse`.
  - U and Z presses in the same cycle suppress both pulses and give `collision` instead.
  - All pulses, including `collision`, are suppressed while `lockout` is high.
- FSM states IDLE, OPEN, WAIT_ACK, LOCK; reset state is IDLE.
  - IDLE → OPEN on a rising edge of `q_opening`: load the timer with `OPEN_TICKS`, clear `bad_count`.
  - OPEN: decrement the timer on each `tick`. When a `tick` arrives with the timer at 1, the timer goes to 0 and the FSM moves to WAIT_ACK.
  - WAIT_ACK: `timerout` = 1. Move to IDLE on the cycle `q_opening` is seen low; `timerout` drops in that same transition.
  - Bad attempts: a rising edge of `q_bad` while in IDLE increments `bad_count`, saturating at `MAX_BAD`. If the incremented value equals `MAX_BAD`, go to LOCK and load the timer with `LOCKOUT_TICKS`.
  - LOCK: `lockout` = 1; decrement the timer on each `tick`. At expiry, clear `bad_count` and go to IDLE.
  - `q_opening` and `q_bad` edges are ignored while in LOCK.
- If `q_opening` falls during OPEN (early exit), go to IDLE with the timer cleared and `timerout` never asserted.
- Edge detection on `q_opening` and `q_bad` uses 1-cycle delayed copies, which reset to 0.

## Timing
- Reset value of every output is 0: `u_pulse`, `z_pulse`, `collision`, `timerout`, `lockout`, `bad_count`, `timer_value`. Debounced levels, counters and synchronizers also reset to 0.
- Button latency: raw edge → pulse = 2 `Clk` (synchronizer) + `DEBOUNCE_TICKS` ticks + 1 `Clk` (registered pulse). Pulse width is exactly 1 `Clk`.
- A held button produces exactly one pulse. Bounces shorter than `DEBOUNCE_TICKS` ticks produce none.
- `timerout` rises 1 `Clk` after the `OPEN_TICKS`-th tick following the OPEN entry. Ticks arriving on the entry cycle are not counted.
- `tick` coinciding with a state entry: the load wins and there is no decrement on that cycle.
- `q_bad` rise on the same cycle as a `q_opening` rise: `q_opening` wins.
- `reset` asserted mid-OPEN or mid-LOCK returns to IDLE on the next edge with all outputs 0.

## Structure
- Package `numlock_pkg` holds the FSM state enum (2-bit encoding: IDLE=0, OPEN=1, WAIT_ACK=2, LOCK=3) and the default parameter constants.
- Sub-module `numlock_debouncer` (synchronizer + counter + rise detect, parameter `DEBOUNCE_TICKS`) is instantiated twice.
- Press arbitration, the FSM and the shared timer live in the top level.

## Test plan
- Press U: raw `btn_u` high for 10 ticks with a bounce at tick 1 → exactly one `u_pulse`, 4 ticks after the last bounce. Same check for Z.
- Collision: `btn_u` and `btn_z` rise on the same cycle and are held 10 ticks → `collision`=1 for 1 cycle, no `u_pulse` or `z_pulse`.
- OPEN dwell: `q_opening` 0→1 → `timerout` rises after the 6th tick, holds for 20 cycles with `q_opening` held, falls the cycle after `q_opening` drops. `bad_count` = 0 at entry.
- Three `q_bad` pulses → `bad_count` 1, 2, 3; `lockout`=1. A button press during lockout → no pulse. After 10 ticks `lockout`=0 and `bad_count`=0.
- Early exit: `q_opening` falls after 3 ticks in OPEN → `timerout` stays 0, FSM in IDLE, `timer_value`=0.
- `reset` pulsed at LOCK tick 5 → next cycle: `lockout`=0, `bad_count`=0, `timer_value`=0.
